crash_course_cpu_control: RTL

//  Sequencer for the crash-course CPU dataloop: fetches 16-bit instructions, decodes them and drives
//  the dataloop's register addresses, immediate, opcode, write enable and system_enabled. Also

---
 rtl/crash_course_cpu_pkg.sv | 39 +++
 rtl/crash_course_cpu_decode.sv | 25 ++
 rtl/crash_course_cpu_control.sv | 84 ++++++++
 3 files changed

// File: rtl/crash_course_cpu_pkg.sv
// crash_course_cpu_pkg: shared opcode, controller state and instruction-format types
package crash_course_cpu_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    FETCH = S_FETCH,
    EXEC  = S_EXEC,
    MEM   = S_MEM,
    HALT  = S_HALT
  } ctrl_state_e;
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_LOAD  = 4'h7,
    OP_STORE = 4'h8,
    OP_CMP   = 4'h9,
    OP_JMP   = 4'hA,
    OP_BZ    = 4'hB,
    OP_BC    = 4'hC,
    OP_ILL_D = 4'hD,
    OP_ILL_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } instr_t;
endpackage

// File: rtl/crash_course_cpu_decode.sv
// crash_course_cpu_decode: combinational opcode classification and branch evaluation
//  op            in  4  IR[15:12]
//  flag_register in  2  [0]=zero, [1]=carry
//  writes_ra..is_illegal out 1 each: instruction class strobes
module crash_course_cpu_decode
  import crash_course_cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [1:0] flag_register,
  output logic       writes_ra,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_branch,
  output logic       branch_taken,
  output logic       is_halt,
  output logic       is_illegal
);
  assign writes_ra    = op >= OP_LDI && op <= OP_XOR;
  assign is_mem       = op == OP_LOAD || op == OP_STORE;
  assign is_store     = op == OP_STORE;
  assign is_branch    = op >= OP_JMP && op <= OP_BC;
  assign branch_taken = op == OP_JMP || (op == OP_BZ && flag_register[0]) || (op == OP_BC && flag_register[1]);
  assign is_halt      = op == OP_HALT;
  assign is_illegal   = op == OP_ILL_D || op == OP_ILL_E;
endmodule

// File: rtl/crash_course_cpu_control.sv
// crash_course_cpu_control: fetch/exec/mem sequencer driving the crash-course CPU dataloop
//  clk, clk_en, sync_rst(active-low), start       control inputs
//  imem_req/addr/ack/rdata                        instruction fetch handshake
//  dmem_req/we/ack                                data access handshake
//  system_enabled, reg_*_addr, reg_a_write_enable, immediate, opcode   dataloop controls
//  flag_register in, pc/halted/illegal_op out      status
module crash_course_cpu_control
  import crash_course_cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clk_en,
  input  logic            sync_rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            system_enabled,
  output logic [3:0]      reg_a_addr,
  output logic            reg_a_write_enable,
  output logic [3:0]      reg_b_addr,
  output logic [3:0]      reg_c_addr,
  output logic [7:0]      immediate,
  output logic [3:0]      opcode,
  input  logic [1:0]      flag_register,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal_op
);
  ctrl_state_e     state, state_nxt;
  instr_t          ir;
  logic [PC_W-1:0] pc_nxt;
  logic            writes_ra, is_mem, is_store, is_branch, branch_taken, is_halt, is_illegal;
  crash_course_cpu_decode u_decode (
    .op           (ir.op),
    .flag_register(flag_register),
    .writes_ra    (writes_ra),
    .is_mem       (is_mem),
    .is_store     (is_store),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .is_halt      (is_halt),
    .is_illegal   (is_illegal)
  );
  assign imem_req           = state == FETCH;
  assign imem_addr          = pc;
  assign dmem_req           = state == MEM;
  assign dmem_we            = dmem_req && is_store;
  assign system_enabled     = state == EXEC || state == MEM;
  assign halted             = state == HALT;
  // load result is written back only in the cycle the ack is actually accepted
  assign reg_a_write_enable = (state == EXEC && writes_ra) || (dmem_req && dmem_ack && clk_en && !is_store);
  assign opcode             = ir.op;
  assign reg_a_addr         = ir.ra;
  assign reg_b_addr         = ir.rb;
  assign reg_c_addr         = ir.rc;
  assign immediate          = {ir.rb, ir.rc};
  always_comb begin
    pc_nxt    = is_branch && branch_taken ? PC_W'({ir.rb, ir.rc}) : pc + 1'b1;
    state_nxt = state == IDLE  ? (start ? FETCH : IDLE) :
                state == FETCH ? (imem_ack ? EXEC : FETCH) :
                state == EXEC  ? (is_halt ? HALT : is_mem ? MEM : FETCH) :
                state == MEM   ? (dmem_ack ? FETCH : MEM) : HALT;
  end
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      illegal_op <= 1'b0;
    end else if (clk_en) begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) ir <= instr_t'(imem_rdata);
      if (state == EXEC && !is_halt) pc <= pc_nxt;
      if (state == EXEC && is_illegal) illegal_op <= 1'b1;
    end
  end
endmodule
